ts_sync_recovery: RTL and testbench
===================================

Name: ts_sync_recovery

Overview:
- Receive-side MPEG-TS framer, the counterpart to the byte-stream TS source (mpeg_data/mpeg_valid/mpeg_sync) that feeds logic_ram.
- Takes an unframed byte stream (data + valid only) and hunts for 0x47 sync bytes at a 188-byte pitch.
- Declares lock after consecutive confirmations, then re-emits the stream packet-aligned with a regenerated sync strobe.
- Flywheels through isolated sync errors and drops lock after repeated misses.

Parameters:
PACK_BYTE_SIZE, 188, bytes per TS packet
SYNC_BYTE, 8'h47, sync byte value
LOCK_COUNT, 3, consecutive good sync bytes (including the first) required to lock; range 2..15
UNLOCK_COUNT, 3, consecutive bad sync bytes in LOCKED that force loss of lock; range 1..15

Ports:
mpeg_clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
mpeg_data  in  8  input byte
mpeg_valid  in  1  mpeg_data valid this cycle; gaps allowed, no backpressure
ts_out  out  8  aligned output byte
ts_out_valid  out  1  ts_out valid
ts_out_sync  out  1  high with ts_out_valid on byte 0 of each output packet
locked  out  1  high while in LOCKED
sync_lost  out  1  one-cycle pulse on LOCKED->HUNT
packet_count  out  32  packets emitted since reset (increments with each ts_out_sync); wraps modulo 2^32

Behaviour:
- Reset: ts_out=0, ts_out_valid=0, ts_out_sync=0, locked=0, sync_lost=0, packet_count=0, state=HUNT, byte_pos=0, good_cnt=0, bad_cnt=0. Reset asserted mid-packet discards all state immediately; nothing is emitted on the cycle after reset.
- Only cycles with mpeg_valid=1 are examined. Invalid cycles change no state and produce ts_out_valid=0.
- byte_pos counts 0..PACK_BYTE_SIZE-1 per valid byte and wraps to 0. A "sync slot" is a valid byte arriving with byte_pos==0.
- HUNT:
  - A valid byte == SYNC_BYTE sets byte_pos<=1, good_cnt<=1, and moves to VERIFY.
  - Any other byte: remain in HUNT.
- VERIFY:
  - Non-slot bytes advance byte_pos.
  - Slot byte == SYNC_BYTE: good_cnt+1. If this reaches LOCK_COUNT, go to LOCKED on this byte; otherwise stay in VERIFY.
  - Slot byte != SYNC_BYTE: go to HUNT, good_cnt<=0. This byte is not re-examined as a sync candidate; the next valid byte is the first one checked.
- LOCKED:
  - Slot byte == SYNC_BYTE: bad_cnt<=0.
  - Slot byte != SYNC_BYTE: bad_cnt+1. If this reaches UNLOCK_COUNT, go to HUNT, pulse sync_lost one cycle later with the output of that byte, and clear bad_cnt.
  - A false 0x47 in the payload is ignored.
- Output pipeline: fixed 1-cycle latency.
  - ts_out/ts_out_valid/ts_out_sync register the input byte when that byte is processed in LOCKED, or is the byte causing VERIFY->LOCKED.
  - ts_out_sync = that byte was a slot byte. This includes a corrupted slot byte in LOCKED (flywheel), which is passed through unmodified.
  - The byte causing LOCKED->HUNT is not emitted.
- ts_out holds its last value when ts_out_valid=0.
- locked is a registered copy of state==LOCKED, asserting on the same cycle as the first ts_out_sync.
- packet_count increments on the cycle ts_out_sync is driven high.
- State transitions and output registration for a byte happen on the same clock edge; there are no simultaneous conflicting events beyond the per-byte decision above.

Test Plan:
- Clean stream, 1316 bytes (7 packets, byte 0 = 0x47), mpeg_valid every other cycle -> locked and first ts_out_sync one cycle after input byte 376; 5 sync pulses total, last at input byte 1128; packet_count=5; ts_out byte-exact to input bytes 376..1315; sync_lost never pulses.
- 37 bytes of 0x00 garbage before the same stream -> lock on input byte 413; output identical to the previous case.
- Stream whose byte 5 of every packet is 0x47 -> first candidate is byte 0; lock at byte 376 as in the clean case; no sync on payload bytes.
- After lock, corrupt a single sync byte (0x00) -> no unlock, ts_out_sync still pulses with ts_out=0x00, bad_cnt clears on the next good slot. Corrupt 3 consecutive sync bytes -> sync_lost pulses one cycle after the third, locked=0, the third byte is not emitted, and re-lock occurs after 3 more good packets.
- Random valid gaps (0–5 idle cycles between bytes) -> identical output byte sequence as the gap-free case; ts_out_valid never high on an idle input cycle +1.
- Assert rst for 1 cycle at input byte 500 while locked -> all outputs return to reset values the next cycle; re-lock requires LOCK_COUNT fresh sync bytes.

Source files
------------

// File: rtl/ts_sync_recovery.sv
// Receive-side MPEG-TS framer: hunts for the sync byte at a fixed packet pitch,
// confirms it over several packets, then re-emits the stream packet-aligned with
// a regenerated sync strobe. Flywheels through isolated sync errors.
module ts_sync_recovery #(
  parameter int unsigned PACK_BYTE_SIZE = 188,
  parameter logic [7:0]  SYNC_BYTE      = 8'h47,
  parameter int unsigned LOCK_COUNT     = 3,
  parameter int unsigned UNLOCK_COUNT   = 3
) (
  input  logic        mpeg_clk,
  input  logic        rst,
  input  logic [7:0]  mpeg_data,
  input  logic        mpeg_valid,
  output logic [7:0]  ts_out,
  output logic        ts_out_valid,
  output logic        ts_out_sync,
  output logic        locked,
  output logic        sync_lost,
  output logic [31:0] packet_count
);

  localparam int unsigned PosW = $clog2(PACK_BYTE_SIZE);
  localparam logic [PosW-1:0] LastPos   = PosW'(PACK_BYTE_SIZE - 1);
  localparam logic [3:0]      LockCnt   = 4'(LOCK_COUNT);
  localparam logic [3:0]      UnlockCnt = 4'(UNLOCK_COUNT);

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e          state_q, state_d;
  logic [PosW-1:0] byte_pos_q, byte_pos_d, pos_inc;
  logic [3:0]      good_cnt_q, good_cnt_d;
  logic [3:0]      bad_cnt_q, bad_cnt_d;
  logic            slot, is_sync;
  logic            emit, emit_sync, lost_d;

  logic [7:0]      ts_out_q;
  logic            ts_out_valid_q, ts_out_sync_q, locked_q, sync_lost_q;
  logic [31:0]     packet_count_q;

  assign slot    = (byte_pos_q == '0);
  assign is_sync = (mpeg_data == SYNC_BYTE);
  assign pos_inc = (byte_pos_q == LastPos) ? '0 : byte_pos_q + 1'b1;

  // Per-valid-byte framing decision: next state, counters and what to emit.
  always_comb begin
    state_d    = state_q;
    byte_pos_d = byte_pos_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    emit       = 1'b0;
    emit_sync  = 1'b0;
    lost_d     = 1'b0;
    if (mpeg_valid) begin
      unique case (state_q)
        StHunt: begin
          if (is_sync) begin
            state_d    = StVerify;
            byte_pos_d = PosW'(1);
            good_cnt_d = 4'd1;
          end
        end
        StVerify: begin
          byte_pos_d = pos_inc;
          if (slot) begin
            if (is_sync) begin
              good_cnt_d = good_cnt_q + 4'd1;
              if (good_cnt_q + 4'd1 == LockCnt) begin
                state_d   = StLocked;
                emit      = 1'b1;
                emit_sync = 1'b1;
              end
            end else begin
              // The failing slot byte is consumed; hunting resumes on the next byte.
              state_d    = StHunt;
              good_cnt_d = '0;
              byte_pos_d = '0;
            end
          end
        end
        StLocked: begin
          byte_pos_d = pos_inc;
          emit       = 1'b1;
          emit_sync  = slot;
          if (slot) begin
            if (is_sync) begin
              bad_cnt_d = '0;
            end else if (bad_cnt_q + 4'd1 == UnlockCnt) begin
              state_d    = StHunt;
              bad_cnt_d  = '0;
              good_cnt_d = '0;
              byte_pos_d = '0;
              emit       = 1'b0;
              emit_sync  = 1'b0;
              lost_d     = 1'b1;
            end else begin
              bad_cnt_d = bad_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State, counters and the one-cycle output pipeline.
  always_ff @(posedge mpeg_clk) begin
    if (rst) begin
      state_q        <= StHunt;
      byte_pos_q     <= '0;
      good_cnt_q     <= '0;
      bad_cnt_q      <= '0;
      ts_out_q       <= '0;
      ts_out_valid_q <= 1'b0;
      ts_out_sync_q  <= 1'b0;
      locked_q       <= 1'b0;
      sync_lost_q    <= 1'b0;
      packet_count_q <= '0;
    end else begin
      state_q        <= state_d;
      byte_pos_q     <= byte_pos_d;
      good_cnt_q     <= good_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
      ts_out_valid_q <= emit;
      ts_out_sync_q  <= emit_sync;
      locked_q       <= (state_d == StLocked);
      sync_lost_q    <= lost_d;
      if (emit) ts_out_q <= mpeg_data;
      if (emit_sync) packet_count_q <= packet_count_q + 32'd1;
    end
  end

  assign ts_out       = ts_out_q;
  assign ts_out_valid = ts_out_valid_q;
  assign ts_out_sync  = ts_out_sync_q;
  assign locked       = locked_q;
  assign sync_lost    = sync_lost_q;
  assign packet_count = packet_count_q;

endmodule

// File: tb/tb_ts_sync_recovery.sv
// Directed bench for ts_sync_recovery: per-byte output capture, then checks of
// lock point, sync placement, payload integrity, flywheel and reset behaviour.
module tb_ts_sync_recovery;

  localparam int MaxLen = 2560;
  localparam int Pkt    = 188;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mpeg_data = '0;
  logic        mpeg_valid = 1'b0;
  logic [7:0]  ts_out;
  logic        ts_out_valid, ts_out_sync, locked, sync_lost;
  logic [31:0] packet_count;

  int checks = 0;
  int failures = 0;

  logic [7:0]  stim [MaxLen];
  int          stim_len;
  logic        obs_v [MaxLen];
  logic        obs_s [MaxLen];
  logic [7:0]  obs_d [MaxLen];
  logic        obs_l [MaxLen];
  logic        obs_lost [MaxLen];
  logic [31:0] obs_pc [MaxLen];
  int          idle_viol;

  int a_first_sync, a_last_sync, a_sync_cnt, a_emit_cnt, a_first_emit;
  int a_mism, a_lost_cnt, a_bad_sync;

  ts_sync_recovery dut (
    .mpeg_clk    (clk),
    .rst         (rst),
    .mpeg_data   (mpeg_data),
    .mpeg_valid  (mpeg_valid),
    .ts_out      (ts_out),
    .ts_out_valid(ts_out_valid),
    .ts_out_sync (ts_out_sync),
    .locked      (locked),
    .sync_lost   (sync_lost),
    .packet_count(packet_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int pos, input int pkt, input bit p5);
    logic [7:0] v;
    if (pos == 0) return 8'h47;
    if (p5 && pos == 5) return 8'h47;
    v = 8'((pos * 7 + pkt * 29 + 1) & 255);
    if (v == 8'h47) v = 8'h46;
    return v;
  endfunction

  task automatic build(input int garbage, input int npk, input bit p5);
    stim_len = garbage + npk * Pkt;
    for (int i = 0; i < MaxLen; i++) begin
      stim[i] = 8'h00;
      obs_v[i] = 1'b0; obs_s[i] = 1'b0; obs_d[i] = '0;
      obs_l[i] = 1'b0; obs_lost[i] = 1'b0; obs_pc[i] = '0;
    end
    for (int i = garbage; i < stim_len; i++)
      stim[i] = gen((i - garbage) % Pkt, (i - garbage) / Pkt, p5);
    idle_viol = 0;
  endtask

  // gap < 0 selects a random 0..5 idle cycles after each byte.
  task automatic send(input int lo, input int hi, input int gap);
    int g;
    @(negedge clk);
    for (int i = lo; i < hi; i++) begin
      mpeg_data  = stim[i];
      mpeg_valid = 1'b1;
      @(negedge clk);
      obs_v[i] = ts_out_valid; obs_s[i] = ts_out_sync; obs_d[i] = ts_out;
      obs_l[i] = locked; obs_lost[i] = sync_lost; obs_pc[i] = packet_count;
      g = (gap < 0) ? int'($urandom_range(0, 5)) : gap;
      if (g > 0) begin
        mpeg_valid = 1'b0;
        repeat (g) begin
          @(negedge clk);
          if (ts_out_valid !== 1'b0) idle_viol++;
        end
      end
    end
    mpeg_valid = 1'b0;
  endtask

  task automatic analyze(input int lo, input int hi, input int off);
    a_first_sync = -1; a_last_sync = -1; a_sync_cnt = 0; a_emit_cnt = 0;
    a_first_emit = -1; a_mism = 0; a_lost_cnt = 0; a_bad_sync = 0;
    for (int i = lo; i < hi; i++) begin
      if (obs_v[i]) begin
        a_emit_cnt++;
        if (a_first_emit < 0) a_first_emit = i;
        if (obs_d[i] !== stim[i]) a_mism++;
      end
      if (obs_s[i]) begin
        a_sync_cnt++;
        if (a_first_sync < 0) a_first_sync = i;
        a_last_sync = i;
        if (!obs_v[i] || ((i - off) % Pkt) != 0) a_bad_sync++;
      end
      if (obs_lost[i]) a_lost_cnt++;
    end
  endtask

  task automatic do_reset();
    mpeg_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_ts_out", 32'(ts_out), 32'h0);
    chk("rst_valid", 32'(ts_out_valid), 32'h0);
    chk("rst_sync", 32'(ts_out_sync), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_sync_lost", 32'(sync_lost), 32'h0);
    chk("rst_pkt_cnt", packet_count, 32'h0);

    // Clean stream, valid every other cycle
    build(0, 7, 1'b0);
    send(0, stim_len, 1);
    analyze(0, stim_len, 0);
    chk("clean_first_sync", 32'(a_first_sync), 32'd376);
    chk("clean_first_emit", 32'(a_first_emit), 32'd376);
    chk("clean_locked_at_first", 32'(obs_l[376]), 32'd1);
    chk("clean_unlocked_before", 32'(obs_l[375]), 32'd0);
    chk("clean_sync_cnt", 32'(a_sync_cnt), 32'd5);
    chk("clean_last_sync", 32'(a_last_sync), 32'd1128);
    chk("clean_pkt_cnt", packet_count, 32'd5);
    chk("clean_pc_at_first", obs_pc[376], 32'd1);
    chk("clean_emit_cnt", 32'(a_emit_cnt), 32'd940);
    chk("clean_data_mism", 32'(a_mism), 32'd0);
    chk("clean_bad_sync", 32'(a_bad_sync), 32'd0);
    chk("clean_sync_lost", 32'(a_lost_cnt), 32'd0);
    chk("clean_idle_valid", 32'(idle_viol), 32'd0);

    // 37 garbage bytes ahead of the stream
    do_reset();
    build(37, 7, 1'b0);
    send(0, stim_len, 0);
    analyze(0, stim_len, 37);
    chk("garb_first_sync", 32'(a_first_sync), 32'd413);
    chk("garb_sync_cnt", 32'(a_sync_cnt), 32'd5);
    chk("garb_emit_cnt", 32'(a_emit_cnt), 32'd940);
    chk("garb_data_mism", 32'(a_mism), 32'd0);
    chk("garb_pkt_cnt", packet_count, 32'd5);

    // False 0x47 at byte 5 of every packet
    do_reset();
    build(0, 7, 1'b1);
    send(0, stim_len, 0);
    analyze(0, stim_len, 0);
    chk("p5_first_sync", 32'(a_first_sync), 32'd376);
    chk("p5_sync_cnt", 32'(a_sync_cnt), 32'd5);
    chk("p5_bad_sync", 32'(a_bad_sync), 32'd0);
    chk("p5_data_mism", 32'(a_mism), 32'd0);
    chk("p5_sync_lost", 32'(a_lost_cnt), 32'd0);

    // Single corrupt sync (pkt 4), then three in a row (pkts 6..8)
    do_reset();
    build(0, 13, 1'b0);
    stim[4 * Pkt] = 8'h00;
    stim[6 * Pkt] = 8'h00;
    stim[7 * Pkt] = 8'h00;
    stim[8 * Pkt] = 8'h00;
    send(0, stim_len, 0);
    analyze(0, stim_len, 0);
    chk("fly_valid", 32'(obs_v[752]), 32'd1);
    chk("fly_sync", 32'(obs_s[752]), 32'd1);
    chk("fly_data", 32'(obs_d[752]), 32'h00);
    chk("fly_locked", 32'(obs_l[1316]), 32'd1);
    chk("unlock_lost_pulse", 32'(obs_lost[1504]), 32'd1);
    chk("unlock_not_emitted", 32'(obs_v[1504]), 32'd0);
    chk("unlock_locked", 32'(obs_l[1504]), 32'd0);
    chk("unlock_lost_cnt", 32'(a_lost_cnt), 32'd1);
    chk("relock_first", 32'(obs_s[2068]), 32'd1);
    chk("relock_not_early", 32'(obs_l[2067]), 32'd0);
    chk("fly_sync_cnt", 32'(a_sync_cnt), 32'd8);
    chk("fly_pkt_cnt", packet_count, 32'd8);
    chk("fly_data_mism", 32'(a_mism), 32'd0);

    // Random 0..5 idle gaps give the same output sequence
    do_reset();
    build(0, 7, 1'b0);
    send(0, stim_len, -1);
    analyze(0, stim_len, 0);
    chk("gap_first_emit", 32'(a_first_emit), 32'd376);
    chk("gap_emit_cnt", 32'(a_emit_cnt), 32'd940);
    chk("gap_data_mism", 32'(a_mism), 32'd0);
    chk("gap_sync_cnt", 32'(a_sync_cnt), 32'd5);
    chk("gap_idle_valid", 32'(idle_viol), 32'd0);

    // Reset at byte 500 while locked
    do_reset();
    build(0, 7, 1'b0);
    send(0, 500, 0);
    chk("mid_locked_before", 32'(obs_l[499]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(ts_out_valid), 32'd0);
    chk("mid_rst_sync", 32'(ts_out_sync), 32'd0);
    chk("mid_rst_ts_out", 32'(ts_out), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_pkt_cnt", packet_count, 32'd0);
    send(500, stim_len, 0);
    analyze(500, stim_len, 0);
    chk("mid_first_emit", 32'(a_first_emit), 32'd940);
    chk("mid_sync_cnt", 32'(a_sync_cnt), 32'd2);
    chk("mid_pkt_cnt", packet_count, 32'd2);
    chk("mid_data_mism", 32'(a_mism), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
